alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 85 ++++++++
 tb/tb_alu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 16-bit combinational ALU with N/Z/C/V flags and a flag capture register.
// Build option ALU_STICKY_V_EN: the captured V bit stays set until reset.
module alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       fun,
    input  logic             flag_we,
    output logic [WIDTH-1:0] R,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic [3:0]       flags_q
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_ASR = 3'b111
    } op_e;

    op_e              op;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [3:0]       shamt;
    logic [3:0]       flags_d;

    assign op    = op_e'(fun);
    assign sum   = {1'b0, A} + {1'b0, B};
    assign diff  = {1'b0, A} - {1'b0, B};
    assign shamt = B[3:0];

    always_comb begin
        R = '0;
        C = 1'b0;
        V = 1'b0;
        unique case (op)
            OP_ADD: begin
                R = sum[WIDTH-1:0];
                C = sum[WIDTH];
                V = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit 16 of the zero-extended difference is the borrow.
                R = diff[WIDTH-1:0];
                C = ~diff[WIDTH];
                V = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: R = A & B;
            OP_OR:  R = A | B;
            OP_NOR: R = ~(A | B);
            OP_SHL: R = A << shamt;
            OP_SHR: R = A >> shamt;
            OP_ASR: R = WIDTH'($signed(A) >>> shamt);
            default: R = '0;
        endcase
    end

    assign N = R[WIDTH-1];
    assign Z = (R == '0);

`ifdef ALU_STICKY_V_EN
    assign flags_d = {N, Z, C, V | flags_q[0]};
`else
    assign flags_d = {N, Z, C, V};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (flag_we) begin
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, flag-register sequences,
// and randomized operations against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  fun;
    logic        flag_we;
    logic [15:0] R;
    logic        N, Z, C, V;
    logic [3:0]  flags_q;

    int checks = 0;
    int errors = 0;

    alu #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .fun     (fun),
        .flag_we (flag_we),
        .R       (R),
        .N       (N),
        .Z       (Z),
        .C       (C),
        .V       (V),
        .flags_q (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic [3:0]  nzcv;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: results from integer arithmetic and signed range checks.
    function automatic logic [19:0] ref_alu(input logic [2:0] f, input logic [15:0] a,
                                            input logic [15:0] b);
        int          ua = int'(a);
        int          ub = int'(b);
        int          sa = int'($signed(a));
        int          sb = int'($signed(b));
        int          p  = 1 << int'(b[3:0]);
        int          res = 0;
        int          sres;
        logic [31:0] t;
        logic [15:0] r;
        logic        c = 1'b0;
        logic        v = 1'b0;
        case (f)
            3'd0: begin
                res  = ua + ub;
                c    = (res > 65535);
                sres = sa + sb;
                v    = (sres > 32767) || (sres < -32768);
            end
            3'd1: begin
                res  = ua - ub;
                c    = (ua >= ub);
                sres = sa - sb;
                v    = (sres > 32767) || (sres < -32768);
            end
            3'd2: res = ua & ub;
            3'd3: res = ua | ub;
            3'd4: res = 65535 - (ua | ub);
            3'd5: res = ua * p;
            3'd6: res = ua / p;
            default: res = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        endcase
        t = res;
        r = t[15:0];
        return {r, r[15], (r == 16'h0000), c, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[$];
    vec_t        v;
    logic [19:0] m;
    logic [3:0]  exp_flags;
    logic [15:0] pick[4];

    initial begin
        rst_n   = 1'b0;
        flag_we = 1'b0;
        A       = '0;
        B       = '0;
        fun     = 3'd0;

        vecs.push_back('{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110});
        vecs.push_back('{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001});
        vecs.push_back('{3'd1, 16'h0003, 16'h0007, 16'hFFFC, 4'b1000});
        vecs.push_back('{3'd1, 16'h8000, 16'h7FFF, 16'h0001, 4'b0011});
        vecs.push_back('{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 4'b1000});
        vecs.push_back('{3'd1, 16'h1234, 16'h1234, 16'h0000, 4'b0110});
        vecs.push_back('{3'd2, 16'h00FF, 16'h0F0F, 16'h000F, 4'b0000});
        vecs.push_back('{3'd3, 16'h00FF, 16'h0F0F, 16'h0FFF, 4'b0000});
        vecs.push_back('{3'd4, 16'h00FF, 16'h0F0F, 16'hF000, 4'b1000});
        vecs.push_back('{3'd5, 16'h0001, 16'h0004, 16'h0010, 4'b0000});
        vecs.push_back('{3'd6, 16'h8000, 16'h0001, 16'h4000, 4'b0000});
        vecs.push_back('{3'd7, 16'h8000, 16'h0001, 16'hC000, 4'b1000});
        vecs.push_back('{3'd7, 16'h8000, 16'hFFF0, 16'h8000, 4'b1000});
        vecs.push_back('{3'd5, 16'h8001, 16'h000F, 16'h8000, 4'b1000});

        // Reset edge clears the register
        tick();
        check("reset_flags", 32'(flags_q), 32'h0);

        // Directed vectors, with reset still asserted (combinational path unaffected)
        foreach (vecs[i]) begin
            v   = vecs[i];
            fun = v.f;
            A   = v.a;
            B   = v.b;
            #1;
            check($sformatf("vec%0d_R", i), 32'(R), 32'(v.r));
            check($sformatf("vec%0d_NZCV", i), 32'({N, Z, C, V}), 32'(v.nzcv));
        end

        // Reset overrides flag_we
        fun = 3'd0; A = 16'h7FFF; B = 16'h0001; flag_we = 1'b1;
        tick();
        check("reset_over_we", 32'(flags_q), 32'h0);

        // First edge after release loads directly
        rst_n = 1'b1;
        tick();
        check("load_1001", 32'(flags_q), 32'h9);

        flag_we = 1'b0; A = 16'h0000; B = 16'h0000;
        tick();
        check("hold_1001", 32'(flags_q), 32'h9);

        fun = 3'd0; A = 16'h0001; B = 16'h0001; flag_we = 1'b1;
        tick();
`ifdef ALU_STICKY_V_EN
        check("sticky_v", 32'(flags_q), 32'h1);
`else
        check("nonsticky_v", 32'(flags_q), 32'h0);
`endif

        rst_n = 1'b0;
        tick();
        check("reset_again", 32'(flags_q), 32'h0);
        rst_n     = 1'b1;
        exp_flags = 4'b0000;

        // Randomized operations plus flag register model
        pick[0] = 16'h0000; pick[1] = 16'hFFFF; pick[2] = 16'h8000; pick[3] = 16'h7FFF;
        for (int i = 0; i < 400; i++) begin
            fun     = 3'($urandom_range(0, 7));
            A       = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
            B       = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
            flag_we = 1'($urandom_range(0, 1));
            rst_n   = ($urandom_range(0, 15) != 0);
            #1;
            m = ref_alu(fun, A, B);
            check("rand_R", 32'(R), 32'(m[19:4]));
            check("rand_NZCV", 32'({N, Z, C, V}), 32'(m[3:0]));
            if (!rst_n)
                exp_flags = 4'b0000;
            else if (flag_we) begin
`ifdef ALU_STICKY_V_EN
                exp_flags = {m[3:1], m[0] | exp_flags[0]};
`else
                exp_flags = m[3:0];
`endif
            end
            tick();
            check("rand_flags", 32'(flags_q), 32'(exp_flags));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
